// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin front end that lets NUM_REQ internal requesters
// share one APB4 slave. It runs the SETUP/ACCESS sequence, handles wait states,
// and issues back-to-back transfers. A wait-state timeout ends a stalled
// transfer, and each completion is returned to the requester that owned it.
module apb_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    input  logic [NUM_REQ*4-1:0]   req_strb,
    input  logic [NUM_REQ*3-1:0]   req_prot,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [31:0]            PADDR,
    output logic [31:0]            PWDATA,
    output logic [3:0]             PSTRB,
    output logic [2:0]             PPROT,
    input  logic [31:0]            PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    // The counter holds the number of wait cycles already spent in ACCESS.
    // The transfer is therefore cut off at the end of ACCESS cycle number TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic               psel_reg, psel_next;
    logic               penable_reg, penable_next;
    logic               pwrite_reg, pwrite_next;
    logic [31:0]        paddr_reg, paddr_next;
    logic [31:0]        pwdata_reg, pwdata_next;
    logic [3:0]         pstrb_reg, pstrb_next;
    logic [2:0]         pprot_reg, pprot_next;
    logic [NUM_REQ-1:0] req_ready_reg, req_ready_next;
    logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
    logic [31:0]        rsp_rdata_reg, rsp_rdata_next;
    logic               rsp_err_reg, rsp_err_next;

    logic [31:0]        addr_arr  [NUM_REQ];
    logic [31:0]        wdata_arr [NUM_REQ];
    logic [3:0]         strb_arr  [NUM_REQ];
    logic [2:0]         prot_arr  [NUM_REQ];
    logic [NUM_REQ-1:0] arb_onehot;
    logic [NUM_REQ-1:0] cur_onehot;
    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   arb_cand;
    logic               do_grant;

    // Split the packed request buses into per-requester fields and build the
    // one-hot decodes for the new winner and the current owner.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]   = req_addr[32*gi +: 32];
            assign wdata_arr[gi]  = req_wdata[32*gi +: 32];
            assign strb_arr[gi]   = req_strb[4*gi +: 4];
            assign prot_arr[gi]   = req_prot[3*gi +: 3];
            assign arb_onehot[gi] = (arb_idx == IDX_W'(gi));
            assign cur_onehot[gi] = (last_grant_reg == IDX_W'(gi));
        end
    endgenerate

    // Round-robin search: start at last_grant+1 and wrap, so the previous
    // winner is checked last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = last_grant_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_cand = (arb_cand == IDX_LAST) ? '0 : arb_cand + IDX_W'(1);
            if (!arb_found && req_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // Next-state logic and next values for every registered output.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        wait_cnt_next   = wait_cnt_reg;
        psel_next       = psel_reg;
        penable_next    = penable_reg;
        pwrite_next     = pwrite_reg;
        paddr_next      = paddr_reg;
        pwdata_next     = pwdata_reg;
        pstrb_next      = pstrb_reg;
        pprot_next      = pprot_reg;
        req_ready_next  = '0;
        rsp_valid_next  = '0;
        rsp_rdata_next  = '0;
        rsp_err_next    = 1'b0;
        do_grant        = 1'b0;

        case (state_reg)
            IDLE: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                do_grant     = arb_found;
            end
            SETUP: begin
                psel_next    = 1'b1;
                penable_next = 1'b1;
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_next = cur_onehot;
                    rsp_err_next   = PSLVERR;
                    rsp_rdata_next = pwrite_reg ? 32'h0 : PRDATA;
                    if (arb_found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_next   = IDLE;
                        psel_next    = 1'b0;
                        penable_next = 1'b0;
                    end
                end else if ((TIMEOUT != 0) && (wait_cnt_reg == CNT_LAST)) begin
                    rsp_valid_next = cur_onehot;
                    rsp_err_next   = 1'b1;
                    state_next     = IDLE;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase

        // Launching a transfer looks the same from IDLE and from a completing
        // ACCESS. PSEL stays high and PENABLE drops for the new SETUP cycle.
        if (do_grant) begin
            state_next      = SETUP;
            psel_next       = 1'b1;
            penable_next    = 1'b0;
            wait_cnt_next   = '0;
            last_grant_next = arb_idx;
            req_ready_next  = arb_onehot;
            pwrite_next     = req_write[arb_idx];
            paddr_next      = addr_arr[arb_idx];
            pwdata_next     = wdata_arr[arb_idx];
            pstrb_next      = req_write[arb_idx] ? strb_arr[arb_idx] : 4'b0000;
            pprot_next      = prot_arr[arb_idx];
        end
    end

    // State and output registers. Reset clears them and gives requester 0 first priority.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDX_LAST;
            wait_cnt_reg   <= '0;
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            pstrb_reg      <= '0;
            pprot_reg      <= '0;
            req_ready_reg  <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            wait_cnt_reg   <= wait_cnt_next;
            psel_reg       <= psel_next;
            penable_reg    <= penable_next;
            pwrite_reg     <= pwrite_next;
            paddr_reg      <= paddr_next;
            pwdata_reg     <= pwdata_next;
            pstrb_reg      <= pstrb_next;
            pprot_reg      <= pprot_next;
            req_ready_reg  <= req_ready_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            rsp_err_reg    <= rsp_err_next;
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign PSEL      = psel_reg;
    assign PENABLE   = penable_reg;
    assign PWRITE    = pwrite_reg;
    assign PADDR     = paddr_reg;
    assign PWDATA    = pwdata_reg;
    assign PSTRB     = pstrb_reg;
    assign PPROT     = pprot_reg;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed bench for apb_req_arbiter with two requesters,
// a small APB slave model that has a programmable wait count and error
// response, and hand-computed expected values.
module tb_apb_req_arbiter;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [5:0]  req_prot;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY, PSLVERR;

    int n_checks = 0;
    int n_pass   = 0;
    int onehot_err = 0;

    apb_req_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave model. PREADY rises after slave_wait low ACCESS cycles. Until then
    // PRDATA carries a marker value, so the read data is only correct if it
    // is taken on the PREADY cycle.
    int          slave_wait = 0;
    logic        slave_err  = 1'b0;
    int          acc_cnt;
    logic [31:0] mem [64];

    assign PREADY  = PSEL && PENABLE && (acc_cnt == slave_wait);
    assign PSLVERR = PREADY && slave_err;
    assign PRDATA  = PREADY ? mem[PADDR[7:2]] : {16'hDEAD, acc_cnt[15:0]};

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            acc_cnt <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else begin
            acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
            if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[7:2]] <= PWDATA;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input int r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req_write[r]        = w;
        req_addr[32*r +: 32] = a;
        req_wdata[32*r +: 32] = d;
        req_strb[4*r +: 4]  = s;
        req_prot[3*r +: 3]  = 3'b010;
        req_valid[r]        = 1'b1;
    endtask

    // Called at a negedge just after issue(). Counts cycles from that point,
    // drops req_valid on the accept pulse, and records the bus activity.
    task automatic wait_rsp(input int r, output logic [31:0] rdata, output logic err,
                            output int rsp_n, output int ready_n, output int psel_n,
                            output int pen_n, output int acc_n, output logic [3:0] strb_or,
                            output logic psel_at_rsp);
        logic done;
        done = 1'b0;
        rdata = '0; err = 1'b0; rsp_n = 0; ready_n = 0; psel_n = 0; pen_n = 0;
        acc_n = 0; strb_or = '0; psel_at_rsp = 1'b1;
        for (int n = 1; n <= 60 && !done; n++) begin
            @(negedge PCLK);
            if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) onehot_err++;
            if (req_ready[r] && ready_n == 0) begin
                ready_n = n;
                req_valid[r] = 1'b0;
            end
            if (PSEL && psel_n == 0) psel_n = n;
            if (PENABLE && pen_n == 0) pen_n = n;
            if (PSEL && PENABLE) begin
                acc_n++;
                strb_or |= PSTRB;
            end
            if (rsp_valid[r]) begin
                done = 1'b1;
                rsp_n = n;
                rdata = rsp_rdata;
                err = rsp_err;
                psel_at_rsp = PSEL;
            end
        end
        check($sformatf("rsp_seen_req%0d", r), {31'h0, done}, 32'h1);
        $display("xfer req%0d: rsp at cycle %0d rdata=%h err=%0d access_cycles=%0d",
                 r, rsp_n, rdata, err, acc_n);
    endtask

    logic [31:0] rd;
    logic        er, pr;
    logic [3:0]  so;
    int          rn, yn, pn, en, an;
    int          grants[$];
    int          rsps[$];
    int          psel_cnt, setup_cnt, last_n, rsp_seen, hit;

    initial begin
        PRESETn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0;

        // Reset state
        @(negedge PCLK);
        check("rst_psel", {31'h0, PSEL}, 32'h0);
        check("rst_penable", {31'h0, PENABLE}, 32'h0);
        check("rst_req_ready", {30'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
        check("rst_paddr", PADDR, 32'h0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Zero-wait write from req0
        slave_wait = 0;
        issue(0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF);
        wait_rsp(0, rd, er, rn, yn, pn, en, an, so, pr);
        check("wr_ready_cycle", yn, 1);
        check("wr_psel_cycle", pn, 1);
        check("wr_penable_cycle", en, 2);
        check("wr_rsp_cycle", rn, 3);
        check("wr_rsp_err", {31'h0, er}, 32'h0);
        check("wr_rsp_rdata", rd, 32'h0);
        check("wr_pstrb", {28'h0, so}, 32'hF);
        check("wr_psel_after", {31'h0, pr}, 32'h0);

        // Read of 0x10 from req1 with 2 wait states. Strobes must be zeroed.
        slave_wait = 2;
        issue(1, 1'b0, 32'h10, 32'h0, 4'h3);
        wait_rsp(1, rd, er, rn, yn, pn, en, an, so, pr);
        check("rd_access_cycles", an, 3);
        check("rd_pstrb", {28'h0, so}, 32'h0);
        check("rd_rdata", rd, 32'hA5A5_1234);
        check("rd_rsp_cycle", rn, 5);
        check("rd_err", {31'h0, er}, 32'h0);

        // Back-to-back round robin after a fresh reset
        @(negedge PCLK);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        slave_wait = 0;
        issue(0, 1'b1, 32'h20, 32'h1111_0000, 4'hF);
        issue(1, 1'b1, 32'h24, 32'h2222_0001, 4'hF);
        psel_cnt = 0; setup_cnt = 0; last_n = 0;
        for (int n = 1; n <= 40 && rsps.size() < 4; n++) begin
            @(negedge PCLK);
            if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) onehot_err++;
            if (req_ready != 2'b00) begin
                grants.push_back(req_ready[1] ? 1 : 0);
                if (grants.size() == 4) req_valid = 2'b00;
            end
            if (PSEL) psel_cnt++;
            if (PSEL && !PENABLE) setup_cnt++;
            if (rsp_valid != 2'b00) begin
                rsps.push_back(rsp_valid[1] ? 1 : 0);
                last_n = n;
            end
        end
        $display("xfer b2b: %0d grants, %0d responses, last response at cycle %0d",
                 grants.size(), rsps.size(), last_n);
        check("b2b_ngrants", grants.size(), 4);
        check("b2b_nrsps", rsps.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_grant%0d", i), grants[i], i % 2);
            check($sformatf("b2b_rsp%0d", i), rsps[i], i % 2);
        end
        check("b2b_psel_cycles", psel_cnt, 8);
        check("b2b_setup_cycles", setup_cnt, 4);
        check("b2b_last_rsp_cycle", last_n, 9);

        // Slave error on a read, followed by a normal read
        @(negedge PCLK);
        slave_err = 1'b1;
        issue(0, 1'b0, 32'h24, 32'h0, 4'hF);
        wait_rsp(0, rd, er, rn, yn, pn, en, an, so, pr);
        check("slverr_err", {31'h0, er}, 32'h1);
        check("slverr_rdata", rd, 32'h2222_0001);
        slave_err = 1'b0;
        issue(1, 1'b0, 32'h20, 32'h0, 4'hF);
        wait_rsp(1, rd, er, rn, yn, pn, en, an, so, pr);
        check("after_err_err", {31'h0, er}, 32'h0);
        check("after_err_rdata", rd, 32'h1111_0000);
        check("after_err_rsp_cycle", rn, 3);

        // Wait-state timeout: the slave never becomes ready
        slave_wait = 1000;
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        wait_rsp(0, rd, er, rn, yn, pn, en, an, so, pr);
        check("tmo_access_cycles", an, 16);
        check("tmo_rsp_cycle", rn, 18);
        check("tmo_err", {31'h0, er}, 32'h1);
        check("tmo_rdata", rd, 32'h0);
        check("tmo_psel", {31'h0, pr}, 32'h0);
        slave_wait = 0;
        issue(1, 1'b1, 32'h30, 32'h3333_3333, 4'hF);
        wait_rsp(1, rd, er, rn, yn, pn, en, an, so, pr);
        check("post_tmo_err", {31'h0, er}, 32'h0);
        check("post_tmo_rsp_cycle", rn, 3);

        // Reset during ACCESS drops the transfer; req0 gets priority afterwards
        slave_wait = 5;
        issue(1, 1'b0, 32'h10, 32'h0, 4'hF);
        hit = 0;
        for (int n = 0; n < 10 && hit == 0; n++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) hit = 1;
        end
        check("rst_mid_reached_access", hit, 1);
        #2 PRESETn = 1'b0;
        #1;
        check("rst_mid_psel", {31'h0, PSEL}, 32'h0);
        check("rst_mid_penable", {31'h0, PENABLE}, 32'h0);
        check("rst_mid_rsp_valid", {30'h0, rsp_valid}, 32'h0);
        @(negedge PCLK);
        req_valid = 2'b00;
        PRESETn = 1'b1;
        issue(1, 1'b0, 32'h10, 32'h0, 4'hF);
        issue(0, 1'b1, 32'h40, 32'h4444_4444, 4'hF);
        hit = 0; rsp_seen = 0;
        for (int n = 0; n < 10 && hit == 0; n++) begin
            @(negedge PCLK);
            if (rsp_valid != 2'b00) rsp_seen++;
            if (req_ready != 2'b00) begin
                hit = 1;
                check("rst_first_grant", {30'h0, req_ready}, 32'h1);
            end
        end
        req_valid = 2'b00;
        check("rst_grant_seen", hit, 1);
        check("rst_no_stale_rsp", rsp_seen, 0);
        $display("xfer reset-recovery: grant_seen=%0d stale_rsp=%0d", hit, rsp_seen);

        check("onehot_violations", onehot_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
